key_matrix_scan: RTL and testbench

- Scans a 4x4 active-low key matrix and reports debounced key presses to core logic.
- Companion input-side block to the board's 8-digit segment display: the display drives active-low digit commons and segment lines, while this block drives active-low one-hot columns and reads the rows back.
- Outputs: a one-cycle event pulse with a 4-bit key code, plus a held-key level.
- Sits between the board keypad pins and user logic, for example a value-entry path feeding the segment display driver.

---
 rtl/key_matrix_scan.sv | 207 ++++++++++++++++++++
 tb/tb_key_matrix_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner: rotates one-hot columns, samples the rows
// once per column and debounces whole-scan results into press/release events.
module key_matrix_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_key_row,
  output logic [3:0] o_key_col,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_pressed
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]        row_meta_q, row_sync_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        col_q, col_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        hits_q, hits_d;      // keys seen this scan, saturating at 2
  logic [3:0]        acc_code_q, acc_code_d;
  state_t            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              pressed_q, pressed_d;

  logic [3:0] sample_s;
  logic [2:0] total_s;
  logic [3:0] res_code_s;
  logic       slot_end_s, scan_end_s, res_none_s, res_single_s;

  // Column rotation and per-scan key accumulation.
  always_comb begin
    sample_s     = ~row_sync_q;
    slot_end_s   = (slot_q == SLOT_LAST);
    scan_end_s   = slot_end_s && (col_idx_q == 2'd3);
    total_s      = {1'b0, hits_q} + popcnt4(sample_s);
    res_none_s   = (total_s == 3'd0);
    res_single_s = (total_s == 3'd1);
    if ((hits_q == 2'd0) && (popcnt4(sample_s) == 3'd1)) begin
      res_code_s = {low_idx(sample_s), col_idx_q};
    end else begin
      res_code_s = acc_code_q;
    end
    slot_d     = slot_q + SLOT_W'(1);
    col_d      = col_q;
    col_idx_d  = col_idx_q;
    hits_d     = hits_q;
    acc_code_d = acc_code_q;
    if (scan_end_s) begin
      slot_d     = '0;
      col_d      = {col_q[2:0], col_q[3]};
      col_idx_d  = 2'd0;
      hits_d     = 2'd0;
      acc_code_d = 4'd0;
    end else if (slot_end_s) begin
      slot_d     = '0;
      col_d      = {col_q[2:0], col_q[3]};
      col_idx_d  = col_idx_q + 2'd1;
      hits_d     = (total_s >= 3'd2) ? 2'd2 : total_s[1:0];
      acc_code_d = res_code_s;
    end else begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  // Debounce state machine, advanced once per completed scan.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    if (scan_end_s) begin
      case (state_q)
        IDLE: begin
          if (res_single_s) begin
            cand_d  = res_code_s;
            cnt_d   = CNT_W'(1);
            state_d = PRESS_DB;
          end else begin
            state_d = IDLE;
          end
        end
        PRESS_DB: begin
          if (res_single_s && (res_code_s == cand_q)) begin
            if ((cnt_q + CNT_W'(1)) == CNT_DONE) begin
              state_d   = HELD;
              cnt_d     = '0;
              code_d    = cand_q;
              valid_d   = 1'b1;
              pressed_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (res_single_s) begin
            cand_d = res_code_s;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (res_none_s) begin
            cnt_d   = CNT_W'(1);
            state_d = REL_DB;
          end else begin
            state_d = HELD;
          end
        end
        REL_DB: begin
          if (res_none_s) begin
            if ((cnt_q + CNT_W'(1)) == CNT_DONE) begin
              state_d   = IDLE;
              cnt_d     = '0;
              pressed_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers; rows double-flopped before use.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      slot_q     <= '0;
      col_q      <= 4'b1110;
      col_idx_q  <= 2'd0;
      hits_q     <= 2'd0;
      acc_code_q <= 4'd0;
      state_q    <= IDLE;
      cand_q     <= 4'd0;
      cnt_q      <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      row_meta_q <= i_key_row;
      row_sync_q <= row_meta_q;
      slot_q     <= slot_d;
      col_q      <= col_d;
      col_idx_q  <= col_idx_d;
      hits_q     <= hits_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      pressed_q  <= pressed_d;
    end
  end

  assign o_key_col     = col_q;
  assign o_key_code    = code_q;
  assign o_key_valid   = valid_q;
  assign o_key_pressed = pressed_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: ideal keypad model driven per scan, checked against
// a scan-history debounce model (a press/release is a run of identical results).
module tb_key_matrix_scan;

  localparam int SD = 8;
  localparam int DB = 3;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic [15:0] keys = 16'h0;

  int n_checks = 0;
  int n_pass   = 0;
  int hist[$];
  bit m_pressed = 1'b0;
  int m_code = 0;
  int m_accepts = 0;
  int seen_valid = 0;
  int stray_valid = 0;

  key_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_row(key_row), .o_key_col(key_col),
    .o_key_code(key_code), .o_key_valid(key_valid), .o_key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Row r pulls low while any pressed key (r,c) has its column driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int classify(input logic [15:0] k);
    int res;
    res = -1;
    if ($countones(k) > 1) res = -2;
    else if ($countones(k) == 1)
      for (int i = 0; i < 16; i++) if (k[i]) res = i;
    return res;
  endfunction

  function automatic logic [3:0] exp_col(input int cyc);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((cyc / SD) % 4));
  endfunction

  // One full scan with key set k applied from slot 0 of column 0.
  task automatic do_scan(input logic [15:0] k, input bit check_col);
    int r;
    bit same;
    bit exp_valid;
    keys = k;
    if (check_col) chk("col", key_col, exp_col(0));
    for (int i = 1; i <= SCAN; i++) begin
      @(posedge clk); #1;
      if (check_col) chk("col", key_col, exp_col(i));
      if (key_valid) seen_valid++;
      if (key_valid && i < SCAN) stray_valid++;
    end
    r = classify(k);
    hist.push_back(r);
    same = (hist.size() >= DB);
    for (int j = 0; j < DB && same; j++)
      if (hist[hist.size()-1-j] != r) same = 1'b0;
    exp_valid = 1'b0;
    if (!m_pressed && same && r >= 0) begin
      m_pressed = 1'b1; m_code = r; exp_valid = 1'b1; m_accepts++;
    end else if (m_pressed && same && r == -1) begin
      m_pressed = 1'b0;
    end
    chk("valid", key_valid, exp_valid);
    chk("pressed", key_pressed, m_pressed);
    chk("code", key_code, m_code);
  endtask

  task automatic model_reset();
    hist.delete();
    m_pressed = 1'b0;
    m_code = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [15:0] prev;
  logic [15:0] nk;

  initial begin
    // 1: reset and bare scan
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", key_col, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_pressed", key_pressed, 1'b0);
    chk("rst_code", key_code, 4'd0);
    release_reset();
    do_scan(16'h0, 1'b1);
    do_scan(16'h0, 1'b1);

    // 2: clean press of row2/col1 (code 9) from reset
    rst = 1'b1;
    #1;
    release_reset();
    for (int s = 0; s < 3; s++) do_scan(16'h0200, 1'b0);
    chk("s2_code9", key_code, 4'd9);
    chk("s2_pressed", key_pressed, 1'b1);
    for (int s = 0; s < 10; s++) do_scan(16'h0200, 1'b0);

    // 5: release debounce from HELD on code 9
    do_scan(16'h0, 1'b0);
    do_scan(16'h0, 1'b0);
    do_scan(16'h0200, 1'b0);
    for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);
    chk("s5_released", key_pressed, 1'b0);

    // 3: bounce on row0/col3
    for (int s = 0; s < 6; s++) do_scan((s % 2 == 0) ? 16'h0008 : 16'h0000, 1'b0);

    // 4: multi-key then single survivor
    for (int s = 0; s < 6; s++) do_scan(16'h0021, 1'b0);
    for (int s = 0; s < 3; s++) do_scan(16'h0001, 1'b0);
    chk("s4_code0", key_code, 4'd0);
    for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);

    // 6: reset while HELD, key still down afterwards
    for (int s = 0; s < 4; s++) do_scan(16'h0200, 1'b0);
    repeat (13) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("s6_pressed", key_pressed, 1'b0);
    chk("s6_col", key_col, 4'b1110);
    chk("s6_valid", key_valid, 1'b0);
    repeat (2) @(posedge clk);
    release_reset();
    for (int s = 0; s < 3; s++) do_scan(16'h0200, 1'b0);
    chk("s6_code9", key_code, 4'd9);

    // random key sets with persistence so presses complete
    prev = 16'h0;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(9, 0) < 6) nk = prev;
      else begin
        case ($urandom_range(3, 0))
          0: nk = 16'h0;
          1, 2: nk = 16'h1 << $urandom_range(15, 0);
          default: nk = (16'h1 << $urandom_range(15, 0)) | (16'h1 << $urandom_range(15, 0));
        endcase
      end
      do_scan(nk, (s < 4));
      prev = nk;
    end
    for (int s = 0; s < 4; s++) do_scan(16'h0, 1'b0);

    chk("valid_total", seen_valid, m_accepts);
    chk("stray_valid", stray_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
